// File: rtl/ysyx_22040386_csr_pkg.sv
// rtl/ysyx_22040386_csr_pkg.sv - CSR addresses, bit indices, cause codes and helpers
// Shared by the machine-mode CSR file and its timer sub-module.
package ysyx_22040386_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;
    localparam int MIP_MTIP     = 7;

    localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
    localparam logic [63:0] CAUSE_MTI     = {1'b1, 63'd7};

    // MPP is hardwired to machine mode; only MIE/MPIE are stored.
    localparam logic [63:0] MSTATUS_FIXED = 64'h1800;
    // mtvec/mepc keep 4-byte alignment.
    localparam logic [63:0] ALIGN4_MASK   = ~64'h3;

    // Which single state update wins this cycle.
    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_TRAP,
        ACT_MRET,
        ACT_WRITE
    } csr_act_e;

    function automatic logic [63:0] mstatus_read(input logic mie, input logic mpie);
        logic [63:0] v;
        v = MSTATUS_FIXED;
        v[MSTATUS_MIE]  = mie;
        v[MSTATUS_MPIE] = mpie;
        return v;
    endfunction

endpackage

// File: rtl/ysyx_22040386_csr_if.sv
// rtl/ysyx_22040386_csr_if.sv - WB/ID/CLINT bus between pipeline and CSR file
// master: pipeline side (drives read address, WB retire info, timer MMIO writes)
// slave:  CSR file side (returns CSR read data and selected timer register)
interface ysyx_22040386_csr_if;
    logic [11:0] csr_raddr;
    logic [63:0] csr_rdata;
    logic        wb_csr_wen;
    logic [11:0] wb_csr_waddr;
    logic [63:0] wb_csr_wdata;
    logic        wb_ecall;
    logic        wb_mret;
    logic        wb_timer_intr;
    logic [63:0] wb_trap_pc;
    logic        clint_wen;
    logic        clint_sel;
    logic [63:0] clint_wdata;
    logic [63:0] clint_rdata;

    modport master (
        output csr_raddr, wb_csr_wen, wb_csr_waddr, wb_csr_wdata, wb_ecall, wb_mret,
               wb_timer_intr, wb_trap_pc, clint_wen, clint_sel, clint_wdata,
        input  csr_rdata, clint_rdata
    );

    modport slave (
        input  csr_raddr, wb_csr_wen, wb_csr_waddr, wb_csr_wdata, wb_ecall, wb_mret,
               wb_timer_intr, wb_trap_pc, clint_wen, clint_sel, clint_wdata,
        output csr_rdata, clint_rdata
    );
endinterface

// File: rtl/ysyx_22040386_timer.sv
// rtl/ysyx_22040386_timer.sv - mtime/mtimecmp timer with prescaler, raises MTIP
// Ports: i_clk, i_rst (async high); clint_wen/clint_sel/clint_wdata MMIO write
// (sel 0=mtime, 1=mtimecmp); clint_rdata selected register; mtip = mtime >= mtimecmp.
module ysyx_22040386_timer
    import ysyx_22040386_csr_pkg::*;
#(
    parameter int unsigned TIMER_DIV = 100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        clint_wen,
    input  logic        clint_sel,
    input  logic [63:0] clint_wdata,
    output logic [63:0] clint_rdata,
    output logic        mtip
);

    localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_DIV - 1);

    logic [PW-1:0] presc;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          tick;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            presc    <= '0;
            mtime    <= '0;
            mtimecmp <= '1;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            // An MMIO write to mtime overrides that cycle's tick; the prescaler keeps its phase.
            if (clint_wen && !clint_sel) begin
                mtime <= clint_wdata;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
            if (clint_wen && clint_sel) begin
                mtimecmp <= clint_wdata;
            end
        end
    end

    assign clint_rdata = clint_sel ? mtimecmp : mtime;
    assign mtip        = (mtime >= mtimecmp);

endmodule

// File: rtl/ysyx_22040386_csr_file.sv
// rtl/ysyx_22040386_csr_file.sv - machine-mode CSR file with trap/mret handling and timer
// Ports: i_clk, i_rst (async high); bus (slave modport: ID read port, WB retire info,
// CLINT MMIO); o_mtvec trap target; o_mepc mret target; o_irq_pending = MIE & MTIE & MTIP.
module ysyx_22040386_csr_file
    import ysyx_22040386_csr_pkg::*;
#(
    parameter int unsigned TIMER_DIV = 100,
    parameter logic [63:0] MTVEC_RST = 64'h0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    ysyx_22040386_csr_if.slave      bus,
    output logic [63:0]             o_mtvec,
    output logic [63:0]             o_mepc,
    output logic                    o_irq_pending
);

    logic        st_mie;
    logic        st_mpie;
    logic        mtie;
    logic [63:0] mtvec;
    logic [63:0] mscratch;
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [63:0] mcycle;
    logic        mtip;
    csr_act_e    act;

    ysyx_22040386_timer #(
        .TIMER_DIV (TIMER_DIV)
    ) u_timer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .clint_wen   (bus.clint_wen),
        .clint_sel   (bus.clint_sel),
        .clint_wdata (bus.clint_wdata),
        .clint_rdata (bus.clint_rdata),
        .mtip        (mtip)
    );

    // Only one source updates trap/CSR state per cycle.
    always_comb begin
        act = ACT_NONE;
        if (bus.wb_timer_intr || bus.wb_ecall) begin
            act = ACT_TRAP;
        end else if (bus.wb_mret) begin
            act = ACT_MRET;
        end else if (bus.wb_csr_wen) begin
            act = ACT_WRITE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_mie   <= 1'b0;
            st_mpie  <= 1'b0;
            mtie     <= 1'b0;
            mtvec    <= MTVEC_RST;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mcycle   <= '0;
        end else begin
            // A CSR write to mcycle below overrides this increment.
            mcycle <= mcycle + 64'd1;
            unique case (act)
                ACT_TRAP: begin
                    mepc    <= bus.wb_trap_pc & ALIGN4_MASK;
                    mcause  <= bus.wb_timer_intr ? CAUSE_MTI : CAUSE_ECALL_M;
                    st_mpie <= st_mie;
                    st_mie  <= 1'b0;
                end
                ACT_MRET: begin
                    st_mie  <= st_mpie;
                    st_mpie <= 1'b1;
                end
                ACT_WRITE: begin
                    case (bus.wb_csr_waddr)
                        CSR_MSTATUS: begin
                            st_mie  <= bus.wb_csr_wdata[MSTATUS_MIE];
                            st_mpie <= bus.wb_csr_wdata[MSTATUS_MPIE];
                        end
                        CSR_MIE:      mtie     <= bus.wb_csr_wdata[MIE_MTIE];
                        CSR_MTVEC:    mtvec    <= bus.wb_csr_wdata & ALIGN4_MASK;
                        CSR_MSCRATCH: mscratch <= bus.wb_csr_wdata;
                        CSR_MEPC:     mepc     <= bus.wb_csr_wdata & ALIGN4_MASK;
                        CSR_MCAUSE:   mcause   <= bus.wb_csr_wdata;
                        CSR_MCYCLE:   mcycle   <= bus.wb_csr_wdata;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Read port reflects registered state only; same-cycle writes are not forwarded.
    always_comb begin
        bus.csr_rdata = '0;
        case (bus.csr_raddr)
            CSR_MSTATUS:  bus.csr_rdata = mstatus_read(st_mie, st_mpie);
            CSR_MIE:      bus.csr_rdata[MIE_MTIE] = mtie;
            CSR_MTVEC:    bus.csr_rdata = mtvec;
            CSR_MSCRATCH: bus.csr_rdata = mscratch;
            CSR_MEPC:     bus.csr_rdata = mepc;
            CSR_MCAUSE:   bus.csr_rdata = mcause;
            CSR_MIP:      bus.csr_rdata[MIP_MTIP] = mtip;
            CSR_MCYCLE:   bus.csr_rdata = mcycle;
            default: ;
        endcase
    end

    assign o_mtvec       = mtvec;
    assign o_mepc        = mepc;
    assign o_irq_pending = st_mie & mtie & mtip;

endmodule

// File: tb/tb_ysyx_22040386_csr_file.sv
// tb/tb_ysyx_22040386_csr_file.sv - self-checking bench for ysyx_22040386_csr_file
module tb_ysyx_22040386_csr_file;

    localparam int TDIV = 4;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic chk_en = 1'b0;
    logic [63:0] mtvec_o;
    logic [63:0] mepc_o;
    logic        irq_o;
    int checks = 0;
    int errors = 0;

    ysyx_22040386_csr_if bus();

    ysyx_22040386_csr_file #(
        .TIMER_DIV (TDIV),
        .MTVEC_RST (64'h0)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .bus           (bus),
        .o_mtvec       (mtvec_o),
        .o_mepc        (mepc_o),
        .o_irq_pending (irq_o)
    );

    always #5 clk = ~clk;

    // Architectural view: whole 64-bit register values as software would read them.
    typedef struct packed {
        logic [63:0] mstatus;
        logic [63:0] mie;
        logic [63:0] mtvec;
        logic [63:0] mscratch;
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] mcycle;
        logic [63:0] mtime;
        logic [63:0] mtimecmp;
        logic [31:0] presc;
    } model_t;

    model_t ms;

    function automatic model_t model_reset();
        model_t m;
        m = '0;
        m.mstatus  = 64'h1800;
        m.mtimecmp = ONES;
        return m;
    endfunction

    function automatic model_t model_step(model_t s);
        model_t n;
        n = s;
        n.mcycle = s.mcycle + 64'd1;
        if (bus.wb_timer_intr || bus.wb_ecall) begin
            n.mepc    = {bus.wb_trap_pc[63:2], 2'b00};
            n.mcause  = bus.wb_timer_intr ? 64'h8000_0000_0000_0007 : 64'd11;
            n.mstatus = 64'h1800 | (s.mstatus[3] ? 64'h80 : 64'h0);
        end else if (bus.wb_mret) begin
            n.mstatus = 64'h1880 | (s.mstatus[7] ? 64'h8 : 64'h0);
        end else if (bus.wb_csr_wen) begin
            case (bus.wb_csr_waddr)
                12'h300: n.mstatus  = 64'h1800 | (bus.wb_csr_wdata & 64'h88);
                12'h304: n.mie      = bus.wb_csr_wdata & 64'h80;
                12'h305: n.mtvec    = bus.wb_csr_wdata & ~64'h3;
                12'h340: n.mscratch = bus.wb_csr_wdata;
                12'h341: n.mepc     = bus.wb_csr_wdata & ~64'h3;
                12'h342: n.mcause   = bus.wb_csr_wdata;
                12'hB00: n.mcycle   = bus.wb_csr_wdata;
                default: ;
            endcase
        end
        if (s.presc == TDIV - 1) begin
            n.presc = 0;
            n.mtime = s.mtime + 64'd1;
        end else begin
            n.presc = s.presc + 1;
        end
        if (bus.clint_wen) begin
            if (bus.clint_sel) n.mtimecmp = bus.clint_wdata;
            else               n.mtime    = bus.clint_wdata;
        end
        return n;
    endfunction

    function automatic logic [63:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return ms.mstatus;
            12'h304: return ms.mie;
            12'h305: return ms.mtvec;
            12'h340: return ms.mscratch;
            12'h341: return ms.mepc;
            12'h342: return ms.mcause;
            12'h344: return (ms.mtime >= ms.mtimecmp) ? 64'h80 : 64'h0;
            12'hB00: return ms.mcycle;
            default: return 64'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) ms <= model_reset();
        else     ms <= model_step(ms);
    end

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check64("model_rdata", bus.csr_rdata, model_read(bus.csr_raddr));
            check64("model_clint", bus.clint_rdata, bus.clint_sel ? ms.mtimecmp : ms.mtime);
            check64("model_mtvec", mtvec_o, ms.mtvec);
            check64("model_mepc", mepc_o, ms.mepc);
            check64("model_irq", {63'd0, irq_o},
                    {63'd0, ms.mstatus[3] & ms.mie[7] & (ms.mtime >= ms.mtimecmp)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_read(input logic [11:0] a, input logic [63:0] exp, input string name);
        bus.csr_raddr = a;
        #1;
        check64(name, bus.csr_rdata, exp);
    endtask

    logic [11:0] vec_addr [5] = '{12'h304, 12'h300, 12'h7C0, 12'h341, 12'h340};
    logic [63:0] vec_data [5] = '{ONES, ONES, ONES, 64'h8000_0107, 64'hDEAD_BEEF_CAFE_F00D};
    logic [63:0] vec_exp  [5] = '{64'h80, 64'h1888, 64'h0, 64'h8000_0104, 64'hDEAD_BEEF_CAFE_F00D};

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.csr_raddr = 12'h0;
        bus.wb_csr_wen = 1'b0;
        bus.wb_csr_waddr = 12'h0;
        bus.wb_csr_wdata = 64'h0;
        bus.wb_ecall = 1'b0;
        bus.wb_mret = 1'b0;
        bus.wb_timer_intr = 1'b0;
        bus.wb_trap_pc = 64'h0;
        bus.clint_wen = 1'b0;
        bus.clint_sel = 1'b0;
        bus.clint_wdata = 64'h0;
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        // Timer: DIV=4, mtimecmp=3, MIE=MTIE=1; MTIP rises on the 12th clock after reset.
        bus.wb_csr_wen = 1'b1; bus.wb_csr_waddr = 12'h300; bus.wb_csr_wdata = 64'h8;
        tick();
        bus.wb_csr_waddr = 12'h304; bus.wb_csr_wdata = 64'h80;
        tick();
        bus.wb_csr_wen = 1'b0;
        bus.clint_wen = 1'b1; bus.clint_sel = 1'b1; bus.clint_wdata = 64'd3;
        tick();
        bus.clint_wen = 1'b0; bus.clint_sel = 1'b0;
        repeat (8) tick();
        chk_read(12'h344, 64'h0, "mtip_clk11");
        check64("irq_clk11", {63'd0, irq_o}, 64'd0);
        tick();
        chk_read(12'h344, 64'h80, "mtip_clk12");
        check64("irq_clk12", {63'd0, irq_o}, 64'd1);

        // mtvec write: old value visible in the write cycle, aligned value after.
        bus.wb_csr_wen = 1'b1; bus.wb_csr_waddr = 12'h305; bus.wb_csr_wdata = 64'h8000_0103;
        chk_read(12'h305, 64'h0, "mtvec_same_cycle");
        tick();
        bus.wb_csr_wen = 1'b0;
        chk_read(12'h305, 64'h8000_0100, "mtvec_next");
        check64("o_mtvec", mtvec_o, 64'h8000_0100);

        // ecall then mret.
        bus.wb_ecall = 1'b1; bus.wb_trap_pc = 64'h8000_0010;
        tick();
        bus.wb_ecall = 1'b0;
        chk_read(12'h341, 64'h8000_0010, "mepc_ecall");
        chk_read(12'h342, 64'd11, "mcause_ecall");
        chk_read(12'h300, 64'h1880, "mstatus_ecall");
        bus.wb_mret = 1'b1;
        tick();
        bus.wb_mret = 1'b0;
        chk_read(12'h300, 64'h1888, "mstatus_mret");

        // All sources at once: only the timer trap takes effect.
        bus.wb_timer_intr = 1'b1; bus.wb_ecall = 1'b1; bus.wb_mret = 1'b1;
        bus.wb_csr_wen = 1'b1; bus.wb_csr_waddr = 12'h341; bus.wb_csr_wdata = 64'h1234_5678;
        bus.wb_trap_pc = 64'h8000_0200;
        tick();
        bus.wb_timer_intr = 1'b0; bus.wb_ecall = 1'b0; bus.wb_mret = 1'b0; bus.wb_csr_wen = 1'b0;
        chk_read(12'h342, 64'h8000_0000_0000_0007, "mcause_timer");
        chk_read(12'h341, 64'h8000_0200, "mepc_timer");
        chk_read(12'h300, 64'h1880, "mstatus_timer");

        // mcycle write beats the increment.
        bus.wb_csr_wen = 1'b1; bus.wb_csr_waddr = 12'hB00; bus.wb_csr_wdata = 64'h5;
        tick();
        bus.wb_csr_wen = 1'b0;
        chk_read(12'hB00, 64'h5, "mcycle_write");
        tick();
        chk_read(12'hB00, 64'h6, "mcycle_inc");

        // mtime all ones wraps to zero on the next tick.
        bus.clint_wen = 1'b1; bus.clint_sel = 1'b0; bus.clint_wdata = ONES;
        tick();
        bus.clint_wen = 1'b0;
        check64("mtime_written", bus.clint_rdata, ONES);
        for (int i = 0; i < 2 * TDIV; i++) begin
            tick();
            if (bus.clint_rdata !== ONES) break;
        end
        check64("mtime_wrap", bus.clint_rdata, 64'h0);

        // Field masks, unimplemented address, read-only mip.
        for (int i = 0; i < 5; i++) begin
            bus.wb_csr_wen = 1'b1; bus.wb_csr_waddr = vec_addr[i]; bus.wb_csr_wdata = vec_data[i];
            tick();
            bus.wb_csr_wen = 1'b0;
            chk_read(vec_addr[i], vec_exp[i], "mask_write");
        end
        bus.wb_csr_wen = 1'b1; bus.wb_csr_waddr = 12'h344; bus.wb_csr_wdata = ONES;
        tick();
        bus.wb_csr_wen = 1'b0;
        repeat (2) tick();

        // Asynchronous reset mid-run.
        bus.csr_raddr = 12'h300;
        rst = 1'b1;
        chk_read(12'h300, 64'h1800, "mstatus_rst");
        bus.clint_sel = 1'b1;
        #1;
        check64("mtimecmp_rst", bus.clint_rdata, ONES);
        check64("irq_rst", {63'd0, irq_o}, 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        bus.clint_sel = 1'b0;
        repeat (3) tick();
        chk_read(12'hB00, 64'd3, "mcycle_after_rst");
        chk_read(12'h305, 64'h0, "mtvec_after_rst");

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
